// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared constants for the forwarding / hazard controller.
//   REG_ADDR_WIDTH  default register index width
//   FWD_SEL_NONE    select value meaning "use the ID/EX register value"
//   SLOT_*          bit positions inside a slot's flag vector
//   OPC_BRANCH      RV32 conditional-branch opcode
package fwd_hazard_ctrl_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  localparam int FWD_SEL_NONE = 0;

  localparam int SLOT_VALID   = 0;
  localparam int SLOT_WR_EN   = 1;
  localparam int SLOT_IS_LOAD = 2;
  localparam int SLOT_FLAG_W  = 3;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

endpackage

// File: rtl/fwd_hazard_ctrl_prio_sel.sv
// fwd_prio_sel: youngest-match priority encoder over the tracked slots.
//   match     in  DEPTH  per-slot match of the source register (bit 0 = EX)
//   ready     in  DEPTH  per-slot "result can be forwarded now"
//   sel       out SEL_W  youngest matching slot index if it is ready, else 0
//   not_ready out 1      youngest matching slot exists but cannot forward yet
module fwd_prio_sel
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match,
  input  logic [DEPTH-1:0] ready,
  output logic [SEL_W-1:0] sel,
  output logic             not_ready
);

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel       = SEL_W'(FWD_SEL_NONE);
    not_ready = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (match[k]) begin
        sel       = ready[k] ? SEL_W'(k) : SEL_W'(FWD_SEL_NONE);
        not_ready = !ready[k];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller beside the ID stage. Keeps its own shadow
// pipeline of destination tags (slot0 = EX ... slot DEPTH-1 = MEM/WB) and
// derives forwarding selects and stalls from it.
//   clk, rst_n                 clock, async active-low reset
//   id_*                       decoded ID-stage instruction fields
//   flush                      drop the ID instruction (bubble into EX)
//   ext_stall                  freeze the whole pipeline
//   hazard_stall               hold PC and IF/ID, bubble into EX
//   forwardA/B                 EX operand sources (0 = ID/EX value, k = slot k)
//   forward_comp1/2            ID branch-compare operand sources
//   stall_cnt                  saturating count of hazard stall cycles
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH  = fwd_hazard_ctrl_pkg::REG_ADDR_WIDTH,
  parameter int DEPTH           = 3,
  parameter int LOAD_READY_SLOT = 2,
  parameter int BRANCH_IN_ID    = 1,
  parameter int CNT_W           = 16,
  parameter int SEL_W           = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_rs1_used,
  input  logic                      id_rs2_used,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_wr_en,
  input  logic                      id_is_load,
  input  logic                      id_is_branch,
  input  logic                      flush,
  input  logic                      ext_stall,
  output logic                      hazard_stall,
  output logic [SEL_W-1:0]          forwardA,
  output logic [SEL_W-1:0]          forwardB,
  output logic [SEL_W-1:0]          forward_comp1,
  output logic [SEL_W-1:0]          forward_comp2,
  output logic [CNT_W-1:0]          stall_cnt
);
  import fwd_hazard_ctrl_pkg::*;

  logic [SLOT_FLAG_W-1:0]    s_flag [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] s_rd   [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] ex_rs1, ex_rs2;
  logic                      ex_rs1_used, ex_rs2_used;
  logic [SLOT_FLAG_W-1:0]    id_flag;

  logic [DEPTH-1:0] live, rdy, ex_m1, ex_m2, id_m1, id_m2;
  logic             load_use, br_active, hazard_raw;
  logic             c1_wait, c2_wait, a_wait, b_wait;
  logic             unused_ex_wait;

  always_comb begin
    id_flag               = '0;
    id_flag[SLOT_VALID]   = id_valid;
    id_flag[SLOT_WR_EN]   = id_reg_wr_en;
    id_flag[SLOT_IS_LOAD] = id_is_load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        s_flag[k] <= '0;
        s_rd[k]   <= '0;
      end
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rs1_used <= 1'b0;
      ex_rs2_used <= 1'b0;
    end else if (!ext_stall) begin
      for (int k = 1; k < DEPTH; k++) begin
        s_flag[k] <= s_flag[k-1];
        s_rd[k]   <= s_rd[k-1];
      end
      if (flush || hazard_stall) begin
        s_flag[0]   <= '0;
        s_rd[0]     <= '0;
        ex_rs1      <= '0;
        ex_rs2      <= '0;
        ex_rs1_used <= 1'b0;
        ex_rs2_used <= 1'b0;
      end else begin
        s_flag[0]   <= id_flag;
        s_rd[0]     <= id_rd;
        ex_rs1      <= id_rs1;
        ex_rs2      <= id_rs2;
        ex_rs1_used <= id_rs1_used;
        ex_rs2_used <= id_rs2_used;
      end
    end
  end

  // Slot0 is the EX consumer itself, so EX matches start at slot1; ID matches
  // include slot0 because a producer in EX has no forwardable result yet.
  always_comb begin
    live     = '0;
    rdy      = '0;
    ex_m1    = '0;
    ex_m2    = '0;
    id_m1    = '0;
    id_m2    = '0;
    load_use = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      live[k]  = s_flag[k][SLOT_VALID] & s_flag[k][SLOT_WR_EN] & (s_rd[k] != '0);
      rdy[k]   = (k >= 1) && (!s_flag[k][SLOT_IS_LOAD] || (k >= LOAD_READY_SLOT));
      id_m1[k] = live[k] & id_rs1_used & (s_rd[k] == id_rs1);
      id_m2[k] = live[k] & id_rs2_used & (s_rd[k] == id_rs2);
      if (k >= 1) begin
        ex_m1[k] = live[k] & s_flag[0][SLOT_VALID] & ex_rs1_used & (s_rd[k] == ex_rs1);
        ex_m2[k] = live[k] & s_flag[0][SLOT_VALID] & ex_rs2_used & (s_rd[k] == ex_rs2);
      end
      // A load still this young will not be forwardable when the ID
      // instruction reaches EX next cycle.
      if ((k + 1 < LOAD_READY_SLOT) && s_flag[k][SLOT_IS_LOAD] && (id_m1[k] || id_m2[k]))
        load_use = 1'b1;
    end
  end

  assign br_active = (BRANCH_IN_ID != 0) && id_valid && id_is_branch;

  fwd_prio_sel #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_sel_a (
    .match(ex_m1), .ready(rdy), .sel(forwardA), .not_ready(a_wait)
  );
  fwd_prio_sel #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_sel_b (
    .match(ex_m2), .ready(rdy), .sel(forwardB), .not_ready(b_wait)
  );
  fwd_prio_sel #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_sel_c1 (
    .match(id_m1 & {DEPTH{br_active}}), .ready(rdy), .sel(forward_comp1), .not_ready(c1_wait)
  );
  fwd_prio_sel #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_sel_c2 (
    .match(id_m2 & {DEPTH{br_active}}), .ready(rdy), .sel(forward_comp2), .not_ready(c2_wait)
  );

  // The load-use stall guarantees EX operands never find an unready producer.
  assign unused_ex_wait = a_wait | b_wait;

  assign hazard_raw   = id_valid & (load_use | (br_active & (c1_wait | c2_wait)));
  assign hazard_stall = hazard_raw & ~flush & ~ext_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (hazard_stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;
  import fwd_hazard_ctrl_pkg::*;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_rs1_used, id_rs2_used, id_reg_wr_en, id_is_load, id_is_branch;
  logic flush, ext_stall;
  logic [REG_ADDR_WIDTH-1:0] id_rs1, id_rs2, id_rd;

  // u0: defaults, u1: deeper pipe, u2: branches resolved late + narrow counter
  logic hs0, hs1, hs2;
  logic [1:0]  fa0, fb0, fc1_0, fc2_0;
  logic [2:0]  fa1, fb1, fc1_1, fc2_1;
  logic [1:0]  fa2, fb2, fc1_2, fc2_2;
  logic [15:0] cnt0, cnt1;
  logic [2:0]  cnt2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl u0 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_wr_en(id_reg_wr_en), .id_is_load(id_is_load), .id_is_branch(id_is_branch),
    .flush(flush), .ext_stall(ext_stall), .hazard_stall(hs0), .forwardA(fa0),
    .forwardB(fb0), .forward_comp1(fc1_0), .forward_comp2(fc2_0), .stall_cnt(cnt0)
  );

  fwd_hazard_ctrl #(.DEPTH(5), .LOAD_READY_SLOT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_wr_en(id_reg_wr_en), .id_is_load(id_is_load), .id_is_branch(id_is_branch),
    .flush(flush), .ext_stall(ext_stall), .hazard_stall(hs1), .forwardA(fa1),
    .forwardB(fb1), .forward_comp1(fc1_1), .forward_comp2(fc2_1), .stall_cnt(cnt1)
  );

  fwd_hazard_ctrl #(.BRANCH_IN_ID(0), .CNT_W(3)) u2 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_wr_en(id_reg_wr_en), .id_is_load(id_is_load), .id_is_branch(id_is_branch),
    .flush(flush), .ext_stall(ext_stall), .hazard_stall(hs2), .forwardA(fa2),
    .forwardB(fb2), .forward_comp1(fc1_2), .forward_comp2(fc2_2), .stall_cnt(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_reg_wr_en = 1'b0;
    id_is_load = 1'b0; id_is_branch = 1'b0;
  endtask

  task automatic set_id(input logic [6:0] opc, input int rd, input int rs1, input int rs2);
    id_valid     = 1'b1;
    id_rd        = REG_ADDR_WIDTH'(rd);
    id_rs1       = REG_ADDR_WIDTH'(rs1);
    id_rs2       = REG_ADDR_WIDTH'(rs2);
    id_is_load   = (opc == OPC_LOAD);
    id_is_branch = (opc == OPC_BRANCH);
    id_reg_wr_en = (opc != OPC_BRANCH);
    id_rs1_used  = 1'b1;
    id_rs2_used  = (opc == OPC_OP) || (opc == OPC_BRANCH);
  endtask

  task automatic do_reset();
    idle();
    flush = 1'b0; ext_stall = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    flush = 1'b0; ext_stall = 1'b0;

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      id_valid = 1'($urandom); id_rs1 = REG_ADDR_WIDTH'($urandom); id_rs2 = REG_ADDR_WIDTH'($urandom);
      id_rd = REG_ADDR_WIDTH'($urandom); id_rs1_used = 1'($urandom); id_rs2_used = 1'($urandom);
      id_reg_wr_en = 1'($urandom); id_is_load = 1'($urandom); id_is_branch = 1'($urandom);
      flush = 1'($urandom); ext_stall = 1'($urandom);
      tick();
      chk("rst_hs", 32'(hs0), 0);   chk("rst_fa", 32'(fa0), 0);
      chk("rst_fb", 32'(fb0), 0);   chk("rst_fc1", 32'(fc1_0), 0);
      chk("rst_fc2", 32'(fc2_0), 0); chk("rst_cnt", 32'(cnt0), 0);
    end
    idle(); flush = 1'b0; ext_stall = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("post_rst_hs", 32'(hs0), 0);
    chk("post_rst_fa", 32'(fa0), 0);

    // ALU back-to-back
    do_reset();
    set_id(OPC_OP, 5, 1, 2); #1 chk("alu_hs", 32'(hs0), 0); tick();
    set_id(OPC_OP, 6, 5, 1); #1 chk("alu_hs2", 32'(hs0), 0); tick();
    idle(); #1
    chk("alu_fa_1", 32'(fa0), 1);
    chk("alu_fb_0", 32'(fb0), 0);

    // ALU with nop between
    do_reset();
    set_id(OPC_OP, 5, 1, 2); tick();
    set_id(OPC_OPIMM, 0, 0, 0); tick();
    set_id(OPC_OP, 6, 5, 1); tick();
    idle(); #1
    chk("nop_fa_2", 32'(fa0), 2);

    // rd = x0 never forwards
    do_reset();
    set_id(OPC_OP, 0, 1, 2); tick();
    set_id(OPC_OP, 6, 0, 1); tick();
    idle(); #1
    chk("x0_fa", 32'(fa0), 0);

    // same rd in two slots: youngest wins
    do_reset();
    set_id(OPC_OP, 5, 1, 2); tick();
    set_id(OPC_OP, 5, 3, 4); tick();
    set_id(OPC_OP, 6, 5, 5); tick();
    idle(); #1
    chk("young_fa", 32'(fa0), 1);
    chk("young_fb", 32'(fb0), 1);

    // load-use: one stall, then forward from slot2
    do_reset();
    set_id(OPC_LOAD, 7, 1, 0); #1 chk("lu_hs0", 32'(hs0), 0); tick();
    set_id(OPC_OP, 8, 7, 7); #1 chk("lu_hs1", 32'(hs0), 1); tick();
    #1 chk("lu_hs2", 32'(hs0), 0); tick();
    idle(); #1
    chk("lu_fa", 32'(fa0), 2);
    chk("lu_fb", 32'(fb0), 2);
    chk("lu_cnt", 32'(cnt0), 1);

    // branch after load: two stalls, then compare-forward from slot2
    do_reset();
    set_id(OPC_LOAD, 9, 1, 0); tick();
    set_id(OPC_BRANCH, 0, 9, 2); #1 chk("bl_hs1", 32'(hs0), 1); tick();
    #1 chk("bl_hs2", 32'(hs0), 1); tick();
    #1 chk("bl_hs3", 32'(hs0), 0);
    chk("bl_fc1", 32'(fc1_0), 2);
    chk("bl_fc2", 32'(fc2_0), 0);
    chk("bl_cnt", 32'(cnt0), 2);

    // branch after ALU producer: one stall
    do_reset();
    set_id(OPC_OP, 9, 1, 2); tick();
    set_id(OPC_BRANCH, 0, 2, 9); #1 chk("ba_hs1", 32'(hs0), 1); tick();
    #1 chk("ba_hs2", 32'(hs0), 0);
    chk("ba_fc2", 32'(fc2_0), 1);
    chk("ba_fc1", 32'(fc1_0), 0);
    chk("ba_cnt", 32'(cnt0), 1);

    // hazard coinciding with flush: no stall, bubble enters EX
    do_reset();
    set_id(OPC_LOAD, 7, 1, 0); tick();
    set_id(OPC_OP, 8, 7, 7); flush = 1'b1; #1 chk("fl_hs", 32'(hs0), 0); tick();
    flush = 1'b0;
    set_id(OPC_BRANCH, 0, 8, 0); #1
    chk("fl_bubble_hs", 32'(hs0), 0);
    chk("fl_bubble_fc1", 32'(fc1_0), 0);
    chk("fl_cnt", 32'(cnt0), 0);

    // ext_stall for 3 cycles in the middle of a branch-after-load hazard
    do_reset();
    set_id(OPC_LOAD, 7, 1, 0); tick();
    set_id(OPC_OP, 3, 7, 2); #1 chk("es_lu", 32'(hs0), 1); tick();
    tick();
    set_id(OPC_LOAD, 9, 3, 0); #1 chk("es_fa2", 32'(fa0), 2); tick();
    set_id(OPC_BRANCH, 0, 9, 2); ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("es_hs", 32'(hs0), 0);
      chk("es_fa", 32'(fa0), 1);
      chk("es_cnt", 32'(cnt0), 1);
      tick();
    end
    ext_stall = 1'b0; #1
    chk("es_rel_hs1", 32'(hs0), 1); tick();
    #1 chk("es_rel_hs2", 32'(hs0), 1); tick();
    #1 chk("es_rel_hs3", 32'(hs0), 0);
    chk("es_rel_fc1", 32'(fc1_0), 2);
    chk("es_rel_cnt", 32'(cnt0), 3);

    // reset mid-stall drops hazard_stall asynchronously
    do_reset();
    set_id(OPC_LOAD, 7, 1, 0); tick();
    set_id(OPC_OP, 8, 7, 7); #1 chk("rm_hs1", 32'(hs0), 1);
    rst_n = 1'b0; #1
    chk("rm_hs_async", 32'(hs0), 0);
    rst_n = 1'b1; #1
    chk("rm_hs_after", 32'(hs0), 0);
    chk("rm_cnt", 32'(cnt0), 0);
    tick();

    // DEPTH=5, LOAD_READY_SLOT=3: load stalls two cycles, forwards from slot3
    do_reset();
    set_id(OPC_LOAD, 7, 1, 0); tick();
    set_id(OPC_OP, 8, 7, 7); #1 chk("d5_hs1", 32'(hs1), 1); tick();
    #1 chk("d5_hs2", 32'(hs1), 1); tick();
    #1 chk("d5_hs3", 32'(hs1), 0); tick();
    idle(); #1
    chk("d5_fa", 32'(fa1), 3);
    chk("d5_fb", 32'(fb1), 3);
    chk("d5_cnt", 32'(cnt1), 2);

    // DEPTH=5: oldest slot forwards; DEPTH=3 has already retired it
    do_reset();
    set_id(OPC_OP, 5, 1, 2); tick();
    for (int i = 0; i < 3; i++) begin
      set_id(OPC_OPIMM, 0, 0, 0); tick();
    end
    set_id(OPC_OP, 6, 5, 1); tick();
    idle(); #1
    chk("d5_fa4", 32'(fa1), 4);
    chk("d3_gone", 32'(fa0), 0);

    // BRANCH_IN_ID=0: no compare forwarding, no branch stall
    do_reset();
    set_id(OPC_OP, 9, 1, 2); tick();
    set_id(OPC_BRANCH, 0, 9, 2); #1
    chk("nb_hs", 32'(hs2), 0);
    chk("nb_fc1", 32'(fc1_2), 0);
    tick(); #1
    chk("nb_fc1b", 32'(fc1_2), 0);

    // narrow counter saturates at all-ones
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_id(OPC_LOAD, 7, 1, 0); tick();
      set_id(OPC_OP, 8, 7, 7); tick();
      tick();
      chk("sat_cnt", 32'(cnt2), (i + 1 < 7) ? i + 1 : 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Parametrised forwarding and hazard controller. Successor to the combinational forwarding unit.
- Owns an internal shadow pipeline of destination tags for stages EX..WB, so the datapath no longer has to feed back per-stage rd/wr_en.
- Generates EX-operand forwarding selects, ID-stage branch-compare forwarding selects, and load-use / branch-dependency stalls. Also keeps a saturating stall-cycle counter.
- Sits beside the ID stage of the risc_v core pipeline.

Parameters:
- REG_ADDR_WIDTH, `REG_ADDR_WIDTH, register index width.
- DEPTH, 3, tracked slots after ID: slot0=EX, slot1=EX/MEM, ..., slot DEPTH-1=MEM/WB. Range 3..6.
- LOAD_READY_SLOT, 2, first slot at which load data is forwardable. Range 2..DEPTH-1.
- BRANCH_IN_ID, 1, 1 = branches resolve in ID, so compare-forward and branch stalls are active.
- CNT_W, 16, stall counter width.
- SEL_W, $clog2(DEPTH), select width (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  REG_ADDR_WIDTH  ID source 1
- id_rs2  in  REG_ADDR_WIDTH  ID source 2
- id_rs1_used  in  1  instruction reads rs1
- id_rs2_used  in  1  instruction reads rs2
- id_rd  in  REG_ADDR_WIDTH  ID destination
- id_reg_wr_en  in  1  ID writes rd
- id_is_load  in  1  ID is a load
- id_is_branch  in  1  ID is a conditional branch
- flush  in  1  discard the ID instruction (taken branch/jump)
- ext_stall  in  1  freeze whole pipeline (memory wait)
- hazard_stall  out  1  hold PC and IF/ID, insert bubble into EX
- forwardA  out  SEL_W  EX operand A source: 0 = ID/EX register value, k = slot k
- forwardB  out  SEL_W  EX operand B source, same encoding
- forward_comp1  out  SEL_W  ID compare rs1 source, same encoding
- forward_comp2  out  SEL_W  ID compare rs2 source, same encoding
- stall_cnt  out  CNT_W  hazard stall cycles counted since reset

Behaviour:
- Slot state: {valid, rd, wr_en, is_load} per slot. Slot0 additionally holds rs1, rs2, rs1_used, rs2_used.
- Reset: all slots invalid, all fields 0, stall_cnt=0. All outputs are 0 during and after reset.
- Advance, by priority:
  - ext_stall=1: no slot changes.
  - flush=1: slots shift by one; slot0 receives a bubble.
  - hazard_stall=1: slots shift; slot0 receives a bubble.
  - else: slots shift; slot0 loads the ID fields, valid=id_valid.
- A slot "matches" src r when: valid & wr_en & rd!=0 & rd==r & src used.
- Slot k is "ready" when: k>=1 and (!is_load or k>=LOAD_READY_SLOT).
- forwardA/B:
  - Consider slots 1..DEPTH-1 matching slot0 rs1/rs2.
  - Select the lowest matching index (youngest wins); 0 if none.
  - Zero when slot0 is invalid.
- forward_comp1/2:
  - Active only if BRANCH_IN_ID & id_valid & id_is_branch.
  - Same youngest-ready-match rule, using id_rs1/id_rs2 against slots 1..DEPTH-1.
- hazard_raw asserts when id_valid and either:
  - a slot k < LOAD_READY_SLOT with is_load=1 matches a used ID source, with k+1 < LOAD_READY_SLOT; or
  - BRANCH_IN_ID & id_is_branch and the youngest matching slot for either source is not ready (this includes slot0).
- Stall output: hazard_stall = hazard_raw & ~flush & ~ext_stall.
- Stall durations fall out of per-cycle recomputation, no extra state:
  - ALU producer in EX feeding a branch: 1 cycle.
  - Load in EX feeding ALU use: 1 cycle.
  - Load in EX feeding a branch: 2 cycles.
- Outputs are combinational from slot registers and ID inputs. Zero added latency.
- stall_cnt increments on each cycle with hazard_stall=1 and saturates at all-ones.
- Reset mid-stall: slots clear immediately and hazard_stall drops asynchronously with rst_n.
- rd=0 never matches.
- Equal rd in two slots: the youngest slot wins.

Decomposition:
- Shared package/defines:
  - REG_ADDR_WIDTH.
  - FWD_SEL_NONE=0.
  - Slot field layout constants.
  - BRANCH opcode 7'b1100011.
- One sub-module, fwd_prio_sel: parametrised youngest-ready-match priority encoder. Instantiated 4x (A, B, comp1, comp2).

Test Plan:
- Reset check: hold rst_n=0 with random inputs -> all outputs 0; stall_cnt=0.
- ALU back-to-back: add x5 then sub x6,x5,x1 -> forwardA=1 next cycle; then with a nop between them -> forwardA=2; with rd=x0 -> 0.
- Load-use: lw x7 then add x8,x7,x7 -> hazard_stall=1 for exactly 1 cycle, then forwardA=forwardB=2; stall_cnt=1.
- Branch after load: lw x9 then beq x9,x2 -> 2 stall cycles, then forward_comp1=2; after an ALU producer instead -> 1 stall cycle, then comp1=1.
- Simultaneous events: a hazard coinciding with flush=1 -> hazard_stall=0 and a bubble enters EX. ext_stall=1 for 3 cycles mid-hazard -> slots frozen, forward selects stable, stall_cnt unchanged.
- Parameters: DEPTH=5, LOAD_READY_SLOT=3 -> a load in slot1 stalls ALU use; forwards from slot3 select 3. BRANCH_IN_ID=0 -> comp selects are 0 and no branch stalls. Force stall_cnt near max -> counter saturates at 16'hFFFF.
